// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// conversion FSM states and the active-low glyph table (bit order g..a).
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the glyph for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] sseg_encode(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/sseg_scan_display_conv.sv
// Iterative binary-to-BCD converter (double dabble, one bit per cycle).
// Hex requests load the value straight into the nibble register.
import sseg_pkg::*;

module bcd_iter_converter #(
  parameter int DATA_WIDTH = 9,
  parameter int RES_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hex,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  done,
  output logic [RES_W-1:0]      result
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [RES_W-1:0]      bcd_r;
  logic [CNT_W-1:0]      cnt_r;

  function automatic logic [RES_W-1:0] dabble_step(input logic [RES_W-1:0] bcd,
                                                   input logic bit_in);
    logic [RES_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < RES_W / 4; i++) begin
      adj[4*i +: 4] = (adj[4*i +: 4] >= 4'd5) ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
    end
    return {adj[RES_W-2:0], bit_in};
  endfunction

  // Load on start, then one dabble step per cycle while bits remain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
    end else if (start) begin
      shift_r <= value;
      bcd_r   <= hex ? RES_W'(value) : '0;
      cnt_r   <= hex ? '0 : CNT_W'(DATA_WIDTH);
    end else if (cnt_r != '0) begin
      bcd_r   <= dabble_step(bcd_r, shift_r[DATA_WIDTH-1]);
      shift_r <= shift_r << 1'b1;
      cnt_r   <= cnt_r - 1'b1;
    end else begin
      bcd_r <= bcd_r;
    end
  end

  assign done   = (cnt_r == CNT_W'(1));
  assign result = bcd_r;

endmodule

// File: rtl/sseg_scan_display.sv
// Seven-segment scan driver: valid/busy intake with a one-deep pending slot,
// atomic commit of converted digits, and continuous multiplexed refresh.
import sseg_pkg::*;

module sseg_scan_display #(
  parameter int DATA_WIDTH  = 9,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  value_valid,
  input  logic                  mode_hex,
  input  logic                  blank_leading,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [7:0]            sseg_indicator,
  output logic [DIGITS-1:0]     digits,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CONV_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
  localparam int HEX_DIGITS  = (DATA_WIDTH + 3) / 4;
  localparam int WIDE_DIGITS = (CONV_DIGITS > HEX_DIGITS) ? CONV_DIGITS : HEX_DIGITS;
  localparam int RES_DIGITS  = (WIDE_DIGITS > DIGITS) ? WIDE_DIGITS : DIGITS;
  localparam int RES_W       = 4 * RES_DIGITS;
  localparam int SCAN_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W     = $clog2(REFRESH_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  conv_state_e state_r, state_s;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] cur_value_r, pend_value_r;
  logic                  cur_hex_r, pend_hex_r, pend_valid_r;
  logic [4*DIGITS-1:0]   disp_r;
  logic                  overflow_r, ovf_s;
  logic                  conv_done_s;
  logic [RES_W-1:0]      conv_result_s;
  logic [PRESC_W-1:0]    presc_r;
  logic [SCAN_W-1:0]     scan_r;
  logic [DIGITS-1:0]     digits_r;
  logic [7:0]            sseg_r;
  logic                  upper_zero_s;
  logic [6:0]            glyph_s;

  bcd_iter_converter #(
    .DATA_WIDTH(DATA_WIDTH),
    .RES_W     (RES_W)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (state_r == ST_LOAD),
    .hex   (cur_hex_r),
    .value (cur_value_r),
    .done  (conv_done_s),
    .result(conv_result_s)
  );

  // Next-state logic for the conversion sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = value_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD:   state_s = cur_hex_r ? ST_COMMIT : ST_SHIFT;
      ST_SHIFT:  state_s = conv_done_s ? ST_COMMIT : ST_SHIFT;
      ST_COMMIT: state_s = pend_valid_r ? ST_LOAD : ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Anything living above the visible digits means the value cannot be shown.
  always_comb begin
    ovf_s = 1'b0;
    for (int i = DIGITS; i < RES_DIGITS; i++) begin
      ovf_s = ovf_s | (|conv_result_s[4*i +: 4]);
    end
  end

  // Sequencer, intake/pending slot and atomic display commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      cur_value_r  <= '0;
      cur_hex_r    <= 1'b0;
      pend_value_r <= '0;
      pend_hex_r   <= 1'b0;
      pend_valid_r <= 1'b0;
      disp_r       <= '0;
      overflow_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (state_r == ST_IDLE && value_valid) begin
        cur_value_r <= value;
        cur_hex_r   <= mode_hex;
      end else if (state_r == ST_COMMIT && pend_valid_r) begin
        cur_value_r <= pend_value_r;
        cur_hex_r   <= pend_hex_r;
      end
      // A write landing on the commit that drains the slot refills it for the next run.
      if (state_r != ST_IDLE && value_valid) begin
        pend_value_r <= value;
        pend_hex_r   <= mode_hex;
        pend_valid_r <= 1'b1;
      end else if (state_r == ST_COMMIT && pend_valid_r) begin
        pend_valid_r <= 1'b0;
      end
      if (state_r == ST_COMMIT) begin
        disp_r     <= conv_result_s[4*DIGITS-1:0];
        overflow_r <= ovf_s;
      end
    end
  end

  // Glyph selection for the digit currently being scanned.
  always_comb begin
    upper_zero_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      upper_zero_s = upper_zero_s & ~((i >= int'(scan_r)) & (|disp_r[4*i +: 4]));
    end
    if (overflow_r) begin
      glyph_s = SEG_DASH;
    end else if (blank_leading && (scan_r != '0) && upper_zero_s) begin
      glyph_s = SEG_BLANK;
    end else begin
      glyph_s = sseg_encode(disp_r[4*scan_r +: 4]);
    end
  end

  // Refresh prescaler, scan index and registered tube outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r  <= '0;
      scan_r   <= '0;
      digits_r <= '1;
      sseg_r   <= 8'hFF;
    end else begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
        scan_r  <= (scan_r == SCAN_LAST) ? '0 : scan_r + 1'b1;
      end else begin
        presc_r <= presc_r + 1'b1;
      end
      digits_r <= ~(DIGITS'(1) << scan_r);
      sseg_r   <= {~dp_mask[scan_r], glyph_s};
    end
  end

  assign sseg_indicator = sseg_r;
  assign digits         = digits_r;
  assign busy           = busy_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Directed bench: a 4-digit and a 2-digit driver share one stimulus stream;
// table vectors cover conversion/encoding, hand sequences cover timing corners.
module tb_sseg_scan_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] value;
  logic       value_valid, mode_hex, blank_leading;
  logic [3:0] dp_mask4;
  logic [1:0] dp_mask2;
  logic [7:0] sseg4, sseg2;
  logic [3:0] digits4;
  logic [1:0] digits2;
  logic       busy4, busy2, ovf4, ovf2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sseg_scan_display #(.DATA_WIDTH(9), .DIGITS(4), .REFRESH_DIV(5)) dut4 (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .mode_hex(mode_hex), .blank_leading(blank_leading), .dp_mask(dp_mask4),
    .sseg_indicator(sseg4), .digits(digits4), .busy(busy4), .overflow(ovf4)
  );

  sseg_scan_display #(.DATA_WIDTH(9), .DIGITS(2), .REFRESH_DIV(5)) dut2 (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .mode_hex(mode_hex), .blank_leading(blank_leading), .dp_mask(dp_mask2),
    .sseg_indicator(sseg2), .digits(digits2), .busy(busy2), .overflow(ovf2)
  );

  typedef struct packed {
    logic [8:0]  value;
    logic        hex;
    logic        blank;
    logic [3:0]  dp;
    logic [31:0] lat;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [8:0] v, input logic h);
    @(negedge clk);
    value = v; mode_hex = h; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy4 && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
  endtask

  task automatic grab(output logic [31:0] s4, output logic [3:0] seen4,
                      output logic [15:0] s2, output logic [1:0] seen2);
    logic [3:0] oh4;
    logic [1:0] oh2;
    s4 = '0; seen4 = '0; s2 = '0; seen2 = '0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        oh4 = 4'b0001 << i;
        if (digits4 == ~oh4) begin s4[8*i +: 8] = sseg4; seen4[i] = 1'b1; end
      end
      for (int i = 0; i < 2; i++) begin
        oh2 = 2'b01 << i;
        if (digits2 == ~oh2) begin s2[8*i +: 8] = sseg2; seen2[i] = 1'b1; end
      end
    end
  endtask

  initial begin
    logic [31:0] s4;
    logic [15:0] s2;
    logic [3:0]  seen4, prev;
    logic [1:0]  seen2, seen;
    int n, run, changes, errs, busy_err, seg_err;

    vecs[0] = '{9'd511,   1'b0, 1'b1, 4'b0000, 32'd11, 32'hFF92F9F9};
    vecs[1] = '{9'h1FF,   1'b1, 1'b0, 4'b0000, 32'd2,  32'hC0F98E8E};
    vecs[2] = '{9'd0,     1'b0, 1'b1, 4'b0100, 32'd11, 32'hFF7FFFC0};
    vecs[3] = '{9'd305,   1'b0, 1'b0, 4'b0001, 32'd11, 32'hC0B0C012};
    vecs[4] = '{9'h0AB,   1'b1, 1'b1, 4'b0000, 32'd2,  32'hFFFF8883};
    vecs[5] = '{9'd90,    1'b0, 1'b1, 4'b0000, 32'd11, 32'hFFFF90C0};
    vecs[6] = '{9'h1C6,   1'b1, 1'b0, 4'b1000, 32'd2,  32'h40F9C682};
    vecs[7] = '{9'd407,   1'b0, 1'b1, 4'b0000, 32'd11, 32'hFF99C0F8};

    reset = 1'b1; value = '0; value_valid = 1'b0; mode_hex = 1'b0;
    blank_leading = 1'b0; dp_mask4 = '0; dp_mask2 = '0;
    repeat (3) @(negedge clk);
    check("rst_digits4", digits4, 4'hF);
    check("rst_sseg4", sseg4, 8'hFF);
    check("rst_busy_ovf", {busy4, ovf4, busy2, ovf2}, 4'b0000);
    check("rst_digits2", digits2, 2'b11);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("first_scan_digit", digits4, 4'b1110);
    check("first_scan_seg", sseg4, 8'hC0);

    // Scan order and dwell: each enable held 5 cycles, rotating 0->1->2->3.
    prev = digits4; run = 1; changes = 0; errs = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); @(negedge clk);
      if (digits4 == prev) run++;
      else begin
        if (changes > 0 && run != 5) errs++;
        if (digits4 != {prev[2:0], prev[3]}) errs++;
        changes++; prev = digits4; run = 1;
      end
    end
    check("scan_order_errs", errs, 0);
    check("scan_changes", (changes >= 8) ? 1 : 0, 1);

    for (int v = 0; v < 8; v++) begin
      blank_leading = vecs[v].blank;
      dp_mask4 = vecs[v].dp;
      send(vecs[v].value, vecs[v].hex);
      wait_idle(n);
      check($sformatf("vec%0d_latency", v), n, vecs[v].lat);
      grab(s4, seen4, s2, seen2);
      check($sformatf("vec%0d_seen", v), seen4, 4'hF);
      check($sformatf("vec%0d_segs", v), s4, vecs[v].segs);
      check($sformatf("vec%0d_ovf", v), ovf4, 1'b0);
    end

    // Two-digit overflow then recovery.
    blank_leading = 1'b0; dp_mask4 = '0;
    send(9'd100, 1'b0);
    wait_idle(n);
    check("ovf_latency", n, 11);
    grab(s4, seen4, s2, seen2);
    check("ovf_flag", ovf2, 1'b1);
    check("ovf_dashes", {seen2, s2}, {2'b11, 16'hBFBF});
    send(9'd42, 1'b0);
    wait_idle(n);
    grab(s4, seen4, s2, seen2);
    check("ovf_cleared", ovf2, 1'b0);
    check("val42_segs", {seen2, s2}, {2'b11, 16'h99A4});

    // Pending slot: 10 accepted, 20 and 30 written while busy, newest wins.
    send(9'd10, 1'b0);
    value = 9'd20; value_valid = 1'b1;
    @(negedge clk);
    value = 9'd30;
    @(negedge clk);
    value_valid = 1'b0;
    busy_err = 0; seg_err = 0; seen = '0;
    for (int k = 3; k <= 22; k++) begin
      @(posedge clk); @(negedge clk);
      if (k < 22 && !busy4) busy_err++;
      if (k >= 12) begin
        if (digits2 == 2'b10) begin seen[0] = 1'b1; if (sseg2 != 8'hC0) seg_err++; end
        else if (digits2 == 2'b01) begin seen[1] = 1'b1; if (sseg2 != 8'hF9) seg_err++; end
        else seg_err++;
      end
    end
    check("pend_busy_hold", busy_err, 0);
    check("pend_busy_fall", busy4, 1'b0);
    check("pend_first_commit", {seen, seg_err[7:0]}, {2'b11, 8'd0});
    grab(s4, seen4, s2, seen2);
    check("pend_second_commit", {seen4, s4}, {4'hF, 32'hC0C0B0C0});

    // Reset in the middle of a decimal conversion.
    send(9'd300, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy4, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", {digits4, sseg4, busy4, ovf4}, {4'hF, 8'hFF, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_no_restart", busy4, 1'b0);
    grab(s4, seen4, s2, seen2);
    check("mid_display_zero", {seen4, s4}, {4'hF, 32'hC0C0C0C0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
